// File: rtl/led_chain_controller_pkg.sv
// Shared opcodes, FSM state encoding and instruction layout for the LED chain controller.
package led_chain_controller_pkg;

    typedef enum logic [7:0] {
        OP_NOP       = 8'h00,
        OP_SELECT    = 8'h01,
        OP_WRITE_CH  = 8'h02,
        OP_WRITE_ALL = 8'h03,
        OP_UPDATE    = 8'h04
    } opcode_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SHIFT_LO = 4'd1,
        ST_SHIFT_HI = 4'd2,
        ST_LATCH    = 4'd3,
        ST_DONE     = 4'd4
    } state_e;

    // Instruction word: [31:24] opcode, [23:16] arg, [15:0] data.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  arg;
        logic [15:0] data;
    } instr_t;

    // Index width that stays legal (>=1 bit) when a dimension has a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_chain_controller_gs_timer.sv
// Grayscale timebase: free-running gsclk with a one-period blank pulse after every
// 2^GS_BITS gsclk rising edges; can be frozen with blank forced high, or restarted.
module led_chain_controller_gs_timer
    import led_chain_controller_pkg::*;
#(
    parameter int GS_BITS   = 12,
    parameter int GSCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic force_blank,
    output logic gsclk,
    output logic blank
);

    localparam int DIV_W = idx_width(GSCLK_DIV);
    localparam int CNT_W = GS_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = {1'b1, {GS_BITS{1'b0}}};

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gsclk_q, gsclk_d;
    logic             blank_q, blank_d;
    logic             half_q, half_d;
    logic             tick;

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        gsclk_d = gsclk_q;
        blank_d = blank_q;
        half_d  = half_q;
        tick    = (div_q == DIV_W'(GSCLK_DIV - 1));

        if (restart) begin
            div_d   = '0;
            cnt_d   = '0;
            gsclk_d = 1'b0;
            blank_d = 1'b0;
            half_d  = 1'b0;
        end else if (force_blank) begin
            blank_d = 1'b1;
            gsclk_d = 1'b0;
        end else if (tick) begin
            div_d = '0;
            if (blank_q) begin
                // Blank spans two half-periods, i.e. one full gsclk period.
                if (half_q) begin
                    blank_d = 1'b0;
                    half_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    half_d = 1'b1;
                end
            end else if (!gsclk_q) begin
                gsclk_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end else begin
                gsclk_d = 1'b0;
                if (cnt_q == FULL_COUNT) begin
                    blank_d = 1'b1;
                    half_d  = 1'b0;
                end
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= '0;
            cnt_q   <= '0;
            gsclk_q <= 1'b0;
            blank_q <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            gsclk_q <= gsclk_d;
            blank_q <= blank_d;
            half_q  <= half_d;
        end
    end

    assign gsclk = gsclk_q;
    assign blank = blank_q;

endmodule

// File: rtl/led_chain_controller.sv
// Multi-chain LED driver controller: instruction decode, grayscale shadow array,
// parallel MSB-first shift-out with per-chain latch, and the shared grayscale timebase.
module led_chain_controller
    import led_chain_controller_pkg::*;
#(
    parameter int NUM_CHAINS   = 4,
    parameter int CH_PER_CHAIN = 16,
    parameter int GS_BITS      = 12,
    parameter int SCLK_DIV     = 2,
    parameter int GSCLK_DIV    = 2,
    parameter int LAT_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instruction,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [NUM_CHAINS-1:0] serial,
    output logic                  sclk,
    output logic [NUM_CHAINS-1:0] lat,
    output logic                  gsclk,
    output logic                  blank,
    output logic [3:0]            state,
    output logic                  err
);

    localparam int CHAIN_W = idx_width(NUM_CHAINS);
    localparam int CH_W    = idx_width(CH_PER_CHAIN);
    localparam int GS_W    = idx_width(GS_BITS);
    localparam int SDIV_W  = idx_width(SCLK_DIV);
    localparam int LAT_W   = idx_width(LAT_CYCLES);

    typedef logic [CH_PER_CHAIN-1:0][GS_BITS-1:0] chain_shadow_t;

    instr_t ins;
    assign ins = instruction;

    state_e                          state_q, state_d;
    logic [CHAIN_W-1:0]              sel_q, sel_d;
    logic [NUM_CHAINS-1:0]           mask_q, mask_d;
    logic [CH_W-1:0]                 ch_q, ch_d;
    logic [GS_W-1:0]                 gbit_q, gbit_d;
    logic [SDIV_W-1:0]               div_q, div_d;
    logic [LAT_W-1:0]                lat_cnt_q, lat_cnt_d;
    logic [NUM_CHAINS-1:0]           serial_q, serial_d;
    logic                            sclk_q, sclk_d;
    logic [NUM_CHAINS-1:0]           lat_q, lat_d;
    logic                            err_q, err_d;
    chain_shadow_t [NUM_CHAINS-1:0]  shadow_q, shadow_d;
    logic                            load_bit;
    logic                            mask_bad;
    logic                            unused_data;

    assign unused_data = ^ins.data;

    assign mask_bad = (ins.arg[NUM_CHAINS-1:0] == '0) || ((32'(ins.arg) >> NUM_CHAINS) != 32'd0);

    always_comb begin
        // NOTE: every _d variable is defaulted to its _q first, so no branch leaves one
        // unassigned -- a missing default here would infer a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        mask_d    = mask_q;
        ch_d      = ch_q;
        gbit_d    = gbit_q;
        div_d     = div_q;
        lat_cnt_d = lat_cnt_q;
        serial_d  = serial_q;
        sclk_d    = sclk_q;
        lat_d     = lat_q;
        err_d     = 1'b0;
        shadow_d  = shadow_q;
        load_bit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (ins.opcode)
                        OP_NOP: ;
                        OP_SELECT: begin
                            if (32'(ins.arg) < NUM_CHAINS) sel_d = ins.arg[CHAIN_W-1:0];
                            else                           err_d = 1'b1;
                        end
                        OP_WRITE_CH: begin
                            if (32'(ins.arg) < CH_PER_CHAIN)
                                shadow_d[sel_q][ins.arg[CH_W-1:0]] = ins.data[GS_BITS-1:0];
                            else
                                err_d = 1'b1;
                        end
                        OP_WRITE_ALL: begin
                            for (int k = 0; k < CH_PER_CHAIN; k++)
                                shadow_d[sel_q][k] = ins.data[GS_BITS-1:0];
                        end
                        OP_UPDATE: begin
                            if (mask_bad) begin
                                err_d = 1'b1;
                            end else begin
                                state_d  = ST_SHIFT_LO;
                                mask_d   = ins.arg[NUM_CHAINS-1:0];
                                ch_d     = CH_W'(CH_PER_CHAIN - 1);
                                gbit_d   = GS_W'(GS_BITS - 1);
                                div_d    = '0;
                                sclk_d   = 1'b0;
                                load_bit = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_SHIFT_LO: begin
                if (div_q == SDIV_W'(SCLK_DIV - 1)) begin
                    state_d = ST_SHIFT_HI;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (div_q == SDIV_W'(SCLK_DIV - 1)) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (ch_q == '0 && gbit_q == '0) begin
                        state_d   = ST_LATCH;
                        serial_d  = '0;
                        lat_d     = mask_q;
                        lat_cnt_d = '0;
                    end else begin
                        state_d  = ST_SHIFT_LO;
                        load_bit = 1'b1;
                        if (gbit_q == '0) begin
                            gbit_d = GS_W'(GS_BITS - 1);
                            ch_d   = ch_q - 1'b1;
                        end else begin
                            gbit_d = gbit_q - 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q == LAT_W'(LAT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    lat_d   = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Serial only changes on entry to SHIFT_LO, so it is stable across the sclk rise.
        if (load_bit) begin
            for (int c = 0; c < NUM_CHAINS; c++)
                serial_d[c] = mask_d[c] & shadow_q[c][ch_d][gbit_d];
        end
    end

    // NOTE: reset is synchronous; the shadow array is cleared with everything else
    // because the drivers must read back zeros after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            mask_q    <= '0;
            ch_q      <= '0;
            gbit_q    <= '0;
            div_q     <= '0;
            lat_cnt_q <= '0;
            serial_q  <= '0;
            sclk_q    <= 1'b0;
            lat_q     <= '0;
            err_q     <= 1'b0;
            shadow_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
            state_q   <= state_d;
            sel_q     <= sel_d;
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            gbit_q    <= gbit_d;
            div_q     <= div_d;
            lat_cnt_q <= lat_cnt_d;
            serial_q  <= serial_d;
            sclk_q    <= sclk_d;
            lat_q     <= lat_d;
            err_q     <= err_d;
            shadow_q  <= shadow_d;
        end
    end

    // Timebase is frozen with blank high through LATCH and restarted from zero in DONE.
    led_chain_controller_gs_timer #(
        .GS_BITS   (GS_BITS),
        .GSCLK_DIV (GSCLK_DIV)
    ) u_gs_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (state_d == ST_DONE),
        .force_blank (state_d == ST_LATCH),
        .gsclk       (gsclk),
        .blank       (blank)
    );

    assign instr_ready = (state_q == ST_IDLE);
    assign serial      = serial_q;
    assign sclk        = sclk_q;
    assign lat         = lat_q;
    assign state       = state_q;
    assign err         = err_q;

endmodule

// File: tb/tb_led_chain_controller.sv
// Directed bench for led_chain_controller at default parameters (4 chains x 16 ch x 12 bits).
module tb_led_chain_controller;

    localparam int NC  = 4;
    localparam int CPC = 16;
    localparam int NB  = 192;   // bits per update = 16 * 12

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  serial;
    logic        sclk;
    logic [3:0]  lat;
    logic        gsclk;
    logic        blank;
    logic [3:0]  state;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Capture results of one update (stored MSB-first: first shifted bit at NB-1).
    logic [NB-1:0] cap [NC];
    int            cap_edges, lat_cycles, lat_first, busy_cycles;
    logic [3:0]    lat_val;
    bit            blank_ok, stray, err_seen, done_seen, cap_timeout;

    // Spec-level model of shadow contents and chain selection.
    logic [11:0] m_shadow [NC][CPC];
    int          m_sel;

    led_chain_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .serial      (serial),
        .sclk        (sclk),
        .lat         (lat),
        .gsclk       (gsclk),
        .blank       (blank),
        .state       (state),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < CPC; k++)
                m_shadow[c][k] = 12'h000;
        m_sel = 0;
    endfunction

    // Returns the expected err bit and applies the instruction to the model.
    function automatic bit model_exec(input logic [31:0] ins);
        logic [7:0]  op;
        logic [7:0]  arg;
        logic [11:0] data;
        op   = ins[31:24];
        arg  = ins[23:16];
        data = ins[11:0];
        case (op)
            8'h00: return 1'b0;
            8'h01: begin
                if (int'(arg) < NC) begin m_sel = int'(arg); return 1'b0; end
                return 1'b1;
            end
            8'h02: begin
                if (int'(arg) < CPC) begin m_shadow[m_sel][int'(arg)] = data; return 1'b0; end
                return 1'b1;
            end
            8'h03: begin
                for (int k = 0; k < CPC; k++) m_shadow[m_sel][k] = data;
                return 1'b0;
            end
            8'h04: return (arg[3:0] == 4'h0) || (arg[7:4] != 4'h0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [NB-1:0] expect_chain(input int c);
        logic [NB-1:0] r;
        r = '0;
        for (int k = 0; k < CPC; k++) r[k*12 +: 12] = m_shadow[c][k];
        return r;
    endfunction

    // Presents one instruction and returns #1 after the transfer edge.
    task automatic send(input logic [31:0] ins);
        int waited;
        waited = 0;
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        while (!instr_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!instr_ready) begin
            bad++;
            $display("FAIL send_ready ins=%h ready=%b required=1", ins, instr_ready);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic cmd(input logic [31:0] ins);
        bit e;
        e = model_exec(ins);
        send(ins);
    endtask

    // Observes one shift/latch sequence; starts just after the UPDATE transfer edge.
    task automatic capture(input logic [3:0] mask);
        logic prev_sclk;
        int   cyc;
        prev_sclk = 1'b0;
        cyc = 0;
        cap_edges = 0; lat_cycles = 0; lat_first = -1; busy_cycles = 0; lat_val = '0;
        blank_ok = 1'b1; stray = 1'b0; err_seen = 1'b0; done_seen = 1'b0; cap_timeout = 1'b1;
        for (int c = 0; c < NC; c++) cap[c] = '0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (instr_ready) begin
                cap_timeout = 1'b0;
                break;
            end
            busy_cycles++;
            if (sclk && !prev_sclk) begin
                if (cap_edges < NB)
                    for (int c = 0; c < NC; c++) cap[c][NB-1-cap_edges] = serial[c];
                cap_edges++;
            end
            prev_sclk = sclk;
            if (lat != 4'h0) begin
                if (lat_first < 0) lat_first = cyc;
                lat_cycles++;
                lat_val = lat;
                if (!blank || state != 4'd3) blank_ok = 1'b0;
            end
            if (((serial | lat) & ~mask) != 4'h0) stray = 1'b1;
            if (err) err_seen = 1'b1;
            if (state == 4'd4 && !blank && lat == 4'h0) done_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({serial, sclk, lat, gsclk, blank, err} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%h required=000", {serial, sclk, lat, gsclk, blank, err});
        end
        total++;
        if (instr_ready !== 1'b1 || state !== 4'd0) begin
            bad++;
            $display("FAIL reset_idle ready=%b state=%0d required ready=1 state=0", instr_ready, state);
        end
        rst_n = 1'b1;
        model_clear();
        send(32'h040F_0000);
        capture(4'hF);
        total++;
        if (cap_timeout || cap_edges != NB) begin
            bad++;
            $display("FAIL reset_readback_edges got=%0d required=%0d", cap_edges, NB);
        end
        for (int c = 0; c < NC; c++) begin
            total++;
            if (cap[c] !== '0) begin
                bad++;
                $display("FAIL reset_readback_chain%0d got=%h required=0", c, cap[c]);
            end
        end
    endtask

    task automatic test_single_write();
        logic [NB-1:0] want2;
        want2 = '0;
        want2[47:36] = 12'hABC;   // channel 3 occupies shifted bits 144..155
        cmd(32'h0102_0000);
        cmd(32'h0203_0ABC);
        send(32'h0404_0000);
        capture(4'h4);
        total++;
        if (cap_edges != NB) begin
            bad++; $display("FAIL single_edges got=%0d required=%0d", cap_edges, NB);
        end
        total++;
        if (cap[2] !== want2) begin
            bad++; $display("FAIL single_chain2 got=%h required=%h", cap[2], want2);
        end
        total++;
        if (cap[0] !== '0 || cap[1] !== '0 || cap[3] !== '0) begin
            bad++; $display("FAIL single_unmasked got=%h/%h/%h required=0", cap[0], cap[1], cap[3]);
        end
        total++;
        if (lat_val !== 4'b0100 || lat_cycles != 2) begin
            bad++; $display("FAIL single_lat got=%b x%0d required=0100 x2", lat_val, lat_cycles);
        end
        total++;
        if (lat_first != 769) begin
            bad++; $display("FAIL single_latency got=%0d required=769", lat_first);
        end
        total++;
        if (busy_cycles != 771) begin
            bad++; $display("FAIL single_busy got=%0d required=771", busy_cycles);
        end
        total++;
        if (stray || err_seen || !done_seen || !blank_ok) begin
            bad++;
            $display("FAIL single_flags stray=%b err=%b done=%b blank_ok=%b required 0 0 1 1",
                     stray, err_seen, done_seen, blank_ok);
        end
        total++;
        if (sclk !== 1'b0) begin
            bad++; $display("FAIL single_sclk_idle got=%b required=0", sclk);
        end
    endtask

    task automatic test_write_all();
        for (int c = 0; c < NC; c++) begin
            cmd({8'h01, 8'(c), 16'h0000});
            cmd(32'h0300_0FFF);
        end
        send(32'h040F_0000);
        capture(4'hF);
        for (int c = 0; c < NC; c++) begin
            total++;
            if (cap[c] !== {NB{1'b1}}) begin
                bad++; $display("FAIL all_chain%0d got=%h required=all ones", c, cap[c]);
            end
        end
        total++;
        if (lat_val !== 4'hF || lat_cycles != 2 || lat_first != 769) begin
            bad++;
            $display("FAIL all_lat got=%h x%0d at %0d required=f x2 at 769", lat_val, lat_cycles, lat_first);
        end
        total++;
        if (!blank_ok) begin
            bad++; $display("FAIL all_blank_latch got=0 required=1");
        end
    endtask

    task automatic test_back_to_back();
        int  low;
        bit  e;
        cmd(32'h0101_0000);
        send(32'h0401_0000);
        instruction = 32'h0205_0123;
        instr_valid = 1'b1;
        e = model_exec(32'h0205_0123);
        low = 0;
        @(negedge clk);
        while (!instr_ready && low < 2000) begin
            low++;
            @(negedge clk);
        end
        total++;
        if (low != 771) begin
            bad++; $display("FAIL b2b_ready_low got=%0d required=771", low);
        end
        total++;
        if (state !== 4'd0 || instr_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_idle state=%0d valid=%b required 0 1", state, instr_valid);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        send(32'h0402_0000);
        capture(4'h2);
        total++;
        if (cap[1] !== expect_chain(1)) begin
            bad++; $display("FAIL b2b_write got=%h required=%h", cap[1], expect_chain(1));
        end
    endtask

    task automatic test_errors();
        logic [31:0] bad_ins [5];
        int          pulses;
        bit          e;
        bad_ins[0] = 32'h0107_0000;
        bad_ins[1] = 32'h0210_0001;
        bad_ins[2] = 32'h0900_0000;
        bad_ins[3] = 32'h0400_0000;
        bad_ins[4] = 32'h0410_0000;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            e = model_exec(bad_ins[i]);
            send(bad_ins[i]);
            @(negedge clk);
            if (err === 1'b1 && state === 4'd0) pulses++;
            @(negedge clk);
            total++;
            if (err !== 1'b0 || state !== 4'd0 || sclk !== 1'b0 || lat !== 4'h0) begin
                bad++;
                $display("FAIL err_after%0d err=%b state=%0d sclk=%b lat=%h required 0 0 0 0",
                         i, err, state, sclk, lat);
            end
        end
        total++;
        if (pulses != 5) begin
            bad++; $display("FAIL err_pulses got=%0d required=5", pulses);
        end
        cmd(32'h0000_0000);
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_nop got=%b required=0", err);
        end
        // Selection must still be chain 1 after the rejected SELECT.
        cmd(32'h0200_0555);
        send(32'h040F_0000);
        capture(4'hF);
        for (int c = 0; c < NC; c++) begin
            total++;
            if (cap[c] !== expect_chain(c)) begin
                bad++; $display("FAIL err_shadow_chain%0d got=%h required=%h", c, cap[c], expect_chain(c));
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic prev_sclk;
        int   edges, cyc;
        send(32'h040F_0000);
        prev_sclk = 1'b0;
        edges = 0;
        cyc = 0;
        while (edges < 100 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sclk && !prev_sclk) edges++;
            prev_sclk = sclk;
        end
        total++;
        if (edges != 100) begin
            bad++; $display("FAIL midrst_edges got=%0d required=100", edges);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (sclk !== 1'b0 || serial !== 4'h0 || lat !== 4'h0 || state !== 4'd0 || instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_outputs sclk=%b serial=%h lat=%h state=%0d ready=%b required 0 0 0 0 1",
                     sclk, serial, lat, state, instr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        cmd(32'h0201_0077);   // lands on chain 0: selection was reset
        send(32'h040F_0000);
        capture(4'hF);
        for (int c = 0; c < NC; c++) begin
            total++;
            if (cap[c] !== expect_chain(c)) begin
                bad++; $display("FAIL midrst_chain%0d got=%h required=%h", c, cap[c], expect_chain(c));
            end
        end
    endtask

    task automatic test_gs_timebase();
        int  cyc, width, rises, high_len;
        bit  prev_gs, measuring_high;
        // Blank repeats every (2*4096 + 2) gsclk half-periods of 2 clk: 4096 gsclk
        // periods plus the one-period blank.
        cyc = 0;
        while (!blank && cyc < 20000) begin @(negedge clk); cyc++; end
        total++;
        if (!blank) begin
            bad++; $display("FAIL gs_first_blank got=0 required=1");
        end
        width = 0;
        while (blank && width < 100) begin @(negedge clk); width++; end
        total++;
        if (width != 4) begin
            bad++; $display("FAIL gs_blank_width got=%0d required=4", width);
        end
        rises = 0; cyc = width; prev_gs = gsclk; high_len = 0; measuring_high = 1'b0;
        while (!blank && cyc < 20000) begin
            if (gsclk && !prev_gs) begin
                rises++;
                if (rises == 1) measuring_high = 1'b1;
            end
            if (measuring_high) begin
                if (gsclk) high_len++;
                else measuring_high = 1'b0;
            end
            prev_gs = gsclk;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (rises != 4096) begin
            bad++; $display("FAIL gs_rises got=%0d required=4096", rises);
        end
        total++;
        if (cyc != 16388) begin
            bad++; $display("FAIL gs_blank_period got=%0d required=16388", cyc);
        end
        total++;
        if (high_len != 2) begin
            bad++; $display("FAIL gs_half_period got=%0d required=2", high_len);
        end
        total++;
        if (state !== 4'd0 || err !== 1'b0) begin
            bad++; $display("FAIL gs_idle state=%0d err=%b required 0 0", state, err);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_all();
        test_back_to_back();
        test_errors();
        test_reset_mid_shift();
        test_gs_timebase();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
